// File: rtl/pixel_adc_readout_pkg.sv
// Shared types and constants for the pixel ADC readout slice.
//   DEF_DATA_W      : default ADC code / ramp counter width
//   N_PIX           : pixels per group
//   pix_idx_t       : pixel index type
//   readout_entry_t : {pixel index, ADC code} queued towards the readout bus
//   lowest_set()    : index of the lowest set bit in a pixel request mask
package pixel_adc_readout_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned N_PIX      = 4;

    typedef logic [1:0] pix_idx_t;

    typedef struct packed {
        pix_idx_t                pix;
        logic [DEF_DATA_W-1:0]   data;
    } readout_entry_t;

    // Fixed-priority pick: lowest pixel index wins. Returns 0 for an empty mask.
    function automatic pix_idx_t lowest_set(input logic [N_PIX-1:0] v);
        pix_idx_t idx;
        logic     found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_PIX; i++) begin
            if (v[i] && !found) begin
                idx   = pix_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pixel_readout_fifo.sv
// Synchronous FIFO of readout entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush (pointers, count and storage to 0)
//   push, din  : write request and entry; ignored when full unless popping
//   pop        : advance the head; ignored when empty
//   head       : registered head entry
//   full/empty : occupancy flags
module pixel_readout_fifo
    import pixel_adc_readout_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = readout_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_adc_readout.sv
// Single-slope ADC latch and readout queue for a 4-pixel group.
//   clk, reset        : clock, asynchronous active-low reset
//   erase             : clears conversion state, requests, FIFO and overflow
//   convert           : high for the duration of the ramp
//   read1..read4      : rising edge requests readout of pixel 0..3
//   cmp[3:0]          : per-pixel comparator outputs (synchronous)
//   dout_pix/data     : head entry {pixel index, ADC code}
//   dout_valid/ready  : output stream handshake
//   overflow          : sticky, set when a read request hits a still-pending pixel
//   busy              : ramp running, request pending or FIFO non-empty
module pixel_adc_readout
    import pixel_adc_readout_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              convert,
    input  logic              read1,
    input  logic              read2,
    input  logic              read3,
    input  logic              read4,
    input  logic [N_PIX-1:0]  cmp,
    output logic [1:0]        dout_pix,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overflow,
    output logic              busy
);

    // Entry type sized by this instance's DATA_W rather than the package default.
    typedef struct packed {
        pix_idx_t          pix;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] counter;
    logic [DATA_W-1:0] code [N_PIX];
    logic [N_PIX-1:0]  done;
    logic [N_PIX-1:0]  pending;
    logic              conv_q;
    logic [N_PIX-1:0]  read_q;
    logic              overflow_q;

    logic [N_PIX-1:0]  read_now;
    logic [N_PIX-1:0]  read_rise;
    logic              conv_rise;
    logic              conv_fall;

    pix_idx_t          grant_idx;
    logic [N_PIX-1:0]  pend_clr;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;

    assign read_now  = {read4, read3, read2, read1};
    assign read_rise = read_now & ~read_q;
    assign conv_rise = convert & ~conv_q;
    assign conv_fall = ~convert & conv_q;

    // Arbiter: lowest pending pixel goes first, one push per cycle.
    assign grant_idx = lowest_set(pending);
    assign pop       = dout_valid && dout_ready;
    assign push      = !erase && (|pending) && (!fifo_full || pop);

    always_comb begin
        pend_clr = '0;
        if (push) begin
            pend_clr[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pix  = grant_idx;
        push_entry.data = code[grant_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter    <= '0;
            done       <= '0;
            pending    <= '0;
            conv_q     <= 1'b0;
            read_q     <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < N_PIX; i++) begin
                code[i] <= '0;
            end
        end else begin
            // Edge-detect history keeps tracking the inputs even during erase,
            // so a convert held through erase does not restart the ramp later.
            conv_q <= convert;
            read_q <= read_now;
            if (erase) begin
                counter    <= '0;
                done       <= '0;
                pending    <= '0;
                overflow_q <= 1'b0;
                for (int unsigned i = 0; i < N_PIX; i++) begin
                    code[i] <= '0;
                end
            end else begin
                if (conv_rise) begin
                    counter <= '0;
                    done    <= '0;
                    for (int unsigned i = 0; i < N_PIX; i++) begin
                        code[i] <= '0;
                    end
                end else if (convert) begin
                    if (counter != '1) begin
                        counter <= counter + 1'b1;
                    end
                    // Latch the pre-increment count on the first comparator trip.
                    for (int unsigned i = 0; i < N_PIX; i++) begin
                        if (!done[i] && cmp[i]) begin
                            code[i] <= counter;
                            done[i] <= 1'b1;
                        end
                    end
                end else if (conv_fall) begin
                    // Pixels that never tripped read as full scale.
                    for (int unsigned i = 0; i < N_PIX; i++) begin
                        if (!done[i]) begin
                            code[i] <= '1;
                            done[i] <= 1'b1;
                        end
                    end
                end
                pending    <= (pending & ~pend_clr) | read_rise;
                overflow_q <= overflow_q | (|(read_rise & pending));
            end
        end
    end

    pixel_readout_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .clear (erase),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign dout_pix   = head.pix;
    assign dout_data  = head.data;
    assign overflow   = overflow_q;
    assign busy       = conv_q || (|pending) || !fifo_empty;

endmodule

// File: tb/tb_pixel_adc_readout.sv
module tb_pixel_adc_readout;

    logic       clk = 1'b0;
    logic       reset;
    logic       erase;
    logic       convert;
    logic       read1, read2, read3, read4;
    logic [3:0] cmp;
    logic [1:0] dout_pix;
    logic [7:0] dout_data;
    logic       dout_valid;
    logic       dout_ready;
    logic       overflow;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q [$];
    int         cur_code [4];

    pixel_adc_readout #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .erase      (erase),
        .convert    (convert),
        .read1      (read1),
        .read2      (read2),
        .read3      (read3),
        .read4      (read4),
        .cmp        (cmp),
        .dout_pix   (dout_pix),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: an entry is accepted at the next rising edge whenever
    // valid and ready are both high at the falling edge before it.
    always @(negedge clk) begin
        if (reset === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_unexpected observed=%0h expected=none", {dout_pix, dout_data});
            end else begin
                check("sb_entry", 32'({dout_pix, dout_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_read(input int idx, input logic v);
        case (idx)
            0: read1 = v;
            1: read2 = v;
            2: read3 = v;
            default: read4 = v;
        endcase
    endtask

    function automatic int exp_code(input int ti, input int n);
        if (ti < 0 || ti >= n) return 255;
        if (ti > 255) return 255;
        return ti;
    endfunction

    function automatic logic [9:0] entry(input int idx);
        logic [9:0] e;
        e = {2'(idx), 8'(cur_code[idx])};
        return e;
    endfunction

    // Ramp body: t is the counter value sampled at each edge; ends with the fall edge.
    task automatic ramp(input int n, input int t0, input int t1, input int t2, input int t3);
        int tt [4];
        tt = '{t0, t1, t2, t3};
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 4; i++) cmp[i] = (tt[i] >= 0 && t >= tt[i]);
            tick(1);
        end
        convert = 1'b0;
        cmp     = '0;
        tick(1);
        for (int i = 0; i < 4; i++) cur_code[i] = exp_code(tt[i], n);
    endtask

    task automatic run_conv(input int n, input int t0, input int t1, input int t2, input int t3);
        convert = 1'b1;
        tick(1);
        check("conv_busy", 32'(busy), 32'd1);
        ramp(n, t0, t1, t2, t3);
    endtask

    // Single read with the FIFO empty and the consumer ready.
    task automatic read_one(input int idx);
        exp_q.push_back(entry(idx));
        set_read(idx, 1'b1);
        tick(1);
        check("lat_edge_k", 32'(dout_valid), 32'd0);
        set_read(idx, 1'b0);
        tick(1);
        check("lat_edge_k1", 32'(dout_valid), 32'd1);
        tick(3);
    endtask

    initial begin
        reset = 1'b0; erase = 1'b0; convert = 1'b0; cmp = '0;
        read1 = 1'b0; read2 = 1'b0; read3 = 1'b0; read4 = 1'b0;
        dout_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_pix", 32'(dout_pix), 32'd0);
        check("rst_data", 32'(dout_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(2);

        // Basic conversion and paced reads
        run_conv(300, 10, 200, -1, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) read_one(i);
        check("basic_idle", 32'(busy), 32'd0);

        // Saturation: trips past count 255 read as 255
        run_conv(400, 350, 120, 100, -1);
        read_one(0);
        read_one(2);

        // Simultaneous reads into a stalled FIFO
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(entry(i));
        exp_q.push_back(entry(0));
        read1 = 1'b1; read2 = 1'b1; read3 = 1'b1; read4 = 1'b1;
        tick(1);
        read1 = 1'b0; read2 = 1'b0; read3 = 1'b0; read4 = 1'b0;
        tick(1);
        check("sim_valid", 32'(dout_valid), 32'd1);
        tick(4);
        check("sim_head_stable", 32'({dout_pix, dout_data}), 32'(entry(0)));
        read1 = 1'b1;
        tick(1);
        read1 = 1'b0;
        tick(2);
        check("sim_pending_busy", 32'(busy), 32'd1);
        check("sim_ovf", 32'(overflow), 32'd0);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        tick(1);
        check("sim_refill_head", 32'({dout_pix, dout_data}), 32'(entry(1)));
        dout_ready = 1'b1;
        tick(8);
        check("sim_drained", 32'(dout_valid), 32'd0);
        check("sim_ovf_end", 32'(overflow), 32'd0);

        // Double request on pixel 1 while it is still pending
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(entry(i));
        exp_q.push_back(entry(1));
        read1 = 1'b1; read2 = 1'b1; read3 = 1'b1; read4 = 1'b1;
        tick(1);
        read1 = 1'b0; read2 = 1'b0; read3 = 1'b0; read4 = 1'b0;
        tick(5);
        read2 = 1'b1; tick(1); read2 = 1'b0; tick(1);
        check("dbl_ovf_first", 32'(overflow), 32'd0);
        read2 = 1'b1; tick(1); read2 = 1'b0; tick(1);
        check("dbl_ovf", 32'(overflow), 32'd1);
        dout_ready = 1'b1;
        tick(10);
        check("dbl_drained", 32'(dout_valid), 32'd0);
        check("dbl_ovf_sticky", 32'(overflow), 32'd1);

        // Erase flushes FIFO and overflow
        dout_ready = 1'b0;
        read3 = 1'b1; tick(1); read3 = 1'b0; tick(2);
        check("ers_pre_valid", 32'(dout_valid), 32'd1);
        erase = 1'b1;
        tick(1);
        check("ers_valid", 32'(dout_valid), 32'd0);
        check("ers_ovf", 32'(overflow), 32'd0);
        check("ers_data", 32'(dout_data), 32'd0);
        erase = 1'b0;
        tick(1);

        // Erase priority over convert rise with all comparators high
        erase = 1'b1; convert = 1'b1; cmp = 4'b1111;
        tick(3);
        erase = 1'b0;
        ramp(20, 5, -1, -1, -1);
        dout_ready = 1'b1;
        read_one(0);
        read_one(1);

        // Asynchronous reset mid-ramp with two queued entries
        dout_ready = 1'b0;
        convert = 1'b1;
        tick(20);
        read1 = 1'b1; tick(1); read1 = 1'b0;
        read2 = 1'b1; tick(1); read2 = 1'b0;
        tick(2);
        check("arst_pre_valid", 32'(dout_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        convert = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        run_conv(300, 10, 200, -1, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) read_one(i);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
